// File: rtl/mux_scan_sequencer_pkg.sv
// rtl/mux_scan_sequencer_pkg.sv - shared encodings and sizes for the mux scan sequencer
package mux_scan_sequencer_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  localparam int unsigned CHANNELS = 4;
  localparam int unsigned SEL_W    = 2;
  localparam int unsigned WAIT_W   = 4;

  typedef logic [SEL_W-1:0]  sel_t;
  typedef logic [WAIT_W-1:0] wait_t;

  localparam sel_t LAST_SEL = sel_t'(CHANNELS - 1);

  // Terminal count of the settle window; the counter runs 0..cycles-1.
  function automatic wait_t settle_last(input int unsigned cycles);
    return wait_t'(cycles - 1);
  endfunction

endpackage

// File: rtl/mux_scan_sequencer.sv
// rtl/mux_scan_sequencer.sv - steps a 4:1 mux through its channels and captures a 4-bit snapshot
module mux_scan_sequencer
  import mux_scan_sequencer_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                continuous,
  input  logic                y,
  output logic                s0,
  output logic                s1,
  output logic                busy,
  output logic                done,
  output logic [CHANNELS-1:0] data
);

  localparam wait_t LAST_WAIT = settle_last(SETTLE_CYCLES);

  logic [0:0] state;
  sel_t       sel;
  wait_t      wait_cnt;
  logic [2:0] shadow;

  // Select lines and busy come straight from flops so the mux sees clean edges.
  assign s0   = sel[0];
  assign s1   = sel[1];
  assign busy = (state == ST_SCAN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      sel      <= '0;
      wait_cnt <= '0;
      shadow   <= '0;
      data     <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_SCAN;
            sel      <= '0;
            wait_cnt <= '0;
          end
        end
        ST_SCAN: begin
          // Abort wins even on the completing edge: no done, data untouched.
          if (abort) begin
            state    <= ST_IDLE;
            sel      <= '0;
            wait_cnt <= '0;
            shadow   <= '0;
          end else if (wait_cnt != LAST_WAIT) begin
            wait_cnt <= wait_cnt + wait_t'(1);
          end else if (sel != LAST_SEL) begin
            case (sel)
              2'd0:    shadow[0] <= y;
              2'd1:    shadow[1] <= y;
              default: shadow[2] <= y;
            endcase
            sel      <= sel + sel_t'(1);
            wait_cnt <= '0;
          end else begin
            data     <= {y, shadow};
            done     <= 1'b1;
            sel      <= '0;
            wait_cnt <= '0;
            if (!continuous) begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          sel      <= '0;
          wait_cnt <= '0;
        end
      endcase
    end
  end

endmodule
